bus_requester: RTL and testbench



---
 rtl/bus_arb_pkg.sv | 14 +
 rtl/sync_fifo.sv | 39 +++
 rtl/bus_requester.sv | 102 ++++++++++
 tb/tb_bus_requester.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_arb_pkg.sv
// Shared definitions for the round-robin bus arbiter, its requesters and the bus mux.
package bus_arb_pkg;
    localparam int NUM_PORTS     = 4;
    localparam int DEF_DATA_W    = 32;
    localparam int DEF_DEPTH     = 8;
    localparam int DEF_MAX_BURST = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_XFER,
        ST_RELEASE
    } req_state_e;
endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with show-ahead read; the extra pointer bit separates full from empty.
module sync_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 8,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

    assign rdata = mem[rd_ptr[AW-1:0]];
    assign count = wr_ptr - rd_ptr;
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
endmodule

// File: rtl/bus_requester.sv
// Requester agent: buffers upstream packets, requests the shared bus and bursts
// at most MAX_BURST beats per tenure, always releasing so the arbiter can rotate.
module bus_requester
    import bus_arb_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int DEPTH     = DEF_DEPTH,
    parameter int MAX_BURST = DEF_MAX_BURST
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              req,
    input  logic              gnt,
    output logic              bus_valid,
    output logic [DATA_W-1:0] bus_data,
    output logic              bus_last,
    output logic              err_gnt_lost
);
    localparam int AW = $clog2(DEPTH);
    localparam int BW = $clog2(MAX_BURST + 1);

    req_state_e        state;
    req_state_e        next_state;
    logic [DATA_W-1:0] head_data;
    logic              head_last;
    logic              full;
    logic              empty;
    logic [AW:0]       count;
    logic [AW:0]       pkt_cnt;
    logic [BW-1:0]     beat_cnt;
    logic              push;
    logic              pop;
    logic              active;
    logic              burst_end;

    assign in_ready = !full;
    assign push     = in_valid && in_ready;
    assign pop      = bus_valid;

    sync_fifo #(.WIDTH(DATA_W + 1), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata ({in_data, in_last}),
        .rdata ({head_data, head_last}),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    // A grant seen while still in REQ is already the first transfer cycle,
    // so the first beat goes out combinationally with gnt.
    assign active    = gnt && (state == ST_REQ || state == ST_XFER);
    assign burst_end = pop && (head_last || beat_cnt == BW'(MAX_BURST - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            req   <= 1'b0;
        end else begin
            state <= next_state;
            req   <= (next_state == ST_REQ) || (next_state == ST_XFER);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pkt_cnt  <= '0;
            beat_cnt <= '0;
        end else begin
            case ({push && in_last, pop && head_last})
                2'b10:   pkt_cnt <= pkt_cnt + 1'b1;
                2'b01:   pkt_cnt <= pkt_cnt - 1'b1;
                default: pkt_cnt <= pkt_cnt;
            endcase
            if (!active)  beat_cnt <= '0;
            else if (pop) beat_cnt <= beat_cnt + 1'b1;
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            ST_IDLE:    if (pkt_cnt != '0 || count == (AW+1)'(DEPTH)) next_state = ST_REQ;
            ST_REQ:     if (gnt) next_state = burst_end ? ST_RELEASE : ST_XFER;
            ST_XFER:    if (!gnt || burst_end) next_state = ST_RELEASE;
            ST_RELEASE: if (!gnt) next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        bus_valid    = active && !empty;
        bus_data     = bus_valid ? head_data : '0;
        bus_last     = bus_valid && head_last;
        err_gnt_lost = (state == ST_XFER) && !gnt;
    end
endmodule

// File: tb/tb_bus_requester.sv
// Directed bench for bus_requester with a one-cycle-latency grant model and a beat scoreboard.
module tb_bus_requester;
    localparam int DATA_W    = 32;
    localparam int DEPTH     = 8;
    localparam int MAX_BURST = 4;

    typedef struct packed {
        logic [DATA_W-1:0] d;
        logic              l;
    } beat_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [DATA_W-1:0] in_data = '0;
    logic              in_last = 1'b0;
    logic              req;
    logic              gnt = 1'b0;
    logic              gnt_kill = 1'b0;
    logic              bus_valid;
    logic [DATA_W-1:0] bus_data;
    logic              bus_last;
    logic              err_gnt_lost;

    int    errors = 0;
    int    checks = 0;
    beat_t q[$];
    int    tq[$];
    int    cur_beats = 0;
    int    low_run = 0;
    int    min_gap = 99;
    logic  prev_req = 1'b0;

    bus_requester #(.DATA_W(DATA_W), .DEPTH(DEPTH), .MAX_BURST(MAX_BURST)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_last      (in_last),
        .req          (req),
        .gnt          (gnt),
        .bus_valid    (bus_valid),
        .bus_data     (bus_data),
        .bus_last     (bus_last),
        .err_gnt_lost (err_gnt_lost)
    );

    always #5 clk = ~clk;

    // Arbiter stand-in: grant follows req one cycle later unless forced off.
    always @(posedge clk) gnt <= rst ? 1'b0 : (req && !gnt_kill);

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        beat_t e;
        @(posedge clk);
        @(negedge clk);
        if (bus_valid) begin
            cur_beats++;
            checks++;
            assert (q.size() > 0) else begin
                errors++;
                $error("FAIL stray_beat: observed data=%0h expected no beat", bus_data);
            end
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("bus_data", 64'(bus_data), 64'(e.d));
                chk("bus_last", 64'(bus_last), 64'(e.l));
            end
        end else begin
            chk("idle_bus", 64'({bus_data, bus_last}), 64'd0);
        end
        if (prev_req && !req) begin
            tq.push_back(cur_beats);
            cur_beats = 0;
            low_run   = 0;
        end
        if (!req) low_run++;
        if (req && !prev_req && tq.size() > 0 && low_run < min_gap) min_gap = low_run;
        prev_req = req;
    endtask

    task automatic push_beat(input logic [DATA_W-1:0] d, input logic l);
        int n = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        while (!in_ready && n < 100) begin
            tick();
            n++;
        end
        chk("push_timeout", 64'(in_ready), 64'd1);
        q.push_back('{d: d, l: l});
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while ((q.size() != 0 || req) && n < 300) begin
            tick();
            n++;
        end
        chk("drain_timeout", 64'(n < 300), 64'd1);
        repeat (3) tick();
    endtask

    task automatic clear_stats();
        tq.delete();
        cur_beats = 0;
        min_gap   = 99;
    endtask

    initial begin
        int n;
        // reset state
        repeat (3) tick();
        rst = 1'b0;
        chk("rst_req", 64'(req), 64'd0);
        chk("rst_bus_valid", 64'(bus_valid), 64'd0);
        chk("rst_bus_data", 64'(bus_data), 64'd0);
        chk("rst_bus_last", 64'(bus_last), 64'd0);
        chk("rst_err", 64'(err_gnt_lost), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        tick();

        // single packet: cycle-exact request and beat timing
        clear_stats();
        push_beat(32'hA0A0_0001, 1'b0);
        push_beat(32'hB0B0_0002, 1'b0);
        push_beat(32'hC0C0_0003, 1'b1);
        chk("p1_req_n", 64'(req), 64'd0);
        tick();
        chk("p1_req_n1", 64'(req), 64'd1);
        chk("p1_valid_n1", 64'(bus_valid), 64'd0);
        tick();
        chk("p1_valid_n2", 64'(bus_valid), 64'd1);
        tick();
        chk("p1_valid_n3", 64'(bus_valid), 64'd1);
        tick();
        chk("p1_last_n4", 64'(bus_last), 64'd1);
        tick();
        chk("p1_req_drop", 64'(req), 64'd0);
        chk("p1_valid_drop", 64'(bus_valid), 64'd0);
        wait_done();
        chk("p1_tenures", 64'(tq.size()), 64'd1);

        // split burst: 6 beats over two tenures
        clear_stats();
        for (int i = 0; i < 6; i++) push_beat(32'h2000_0000 + i, i == 5);
        wait_done();
        chk("split_ntenure", 64'(tq.size()), 64'd2);
        if (tq.size() == 2) begin
            chk("split_t0", 64'(tq[0]), 64'd4);
            chk("split_t1", 64'(tq[1]), 64'd2);
        end
        chk("split_gap", 64'(min_gap >= 2), 64'd1);

        // full FIFO triggers a request before the packet is complete
        clear_stats();
        for (int i = 0; i < 7; i++) push_beat(32'h3000_0000 + i, 1'b0);
        chk("full_req_7", 64'(req), 64'd0);
        push_beat(32'h3000_0007, 1'b0);
        chk("full_in_ready", 64'(in_ready), 64'd0);
        chk("full_req_8", 64'(req), 64'd0);
        tick();
        chk("full_req_rise", 64'(req), 64'd1);
        n = 0;
        while (tq.size() == 0 && n < 50) begin
            tick();
            n++;
        end
        chk("full_t0", 64'(tq.size() > 0 ? tq[0] : -1), 64'd4);
        chk("full_ready_back", 64'(in_ready), 64'd1);
        repeat (6) tick();
        chk("full_no_rereq", 64'(req), 64'd0);
        push_beat(32'h3000_0008, 1'b0);
        push_beat(32'h3000_0009, 1'b1);
        wait_done();
        chk("full_ntenure", 64'(tq.size()), 64'd3);
        if (tq.size() == 3) begin
            chk("full_t1", 64'(tq[1]), 64'd4);
            chk("full_t2", 64'(tq[2]), 64'd2);
        end

        // grant revoked after the first beat
        clear_stats();
        push_beat(32'h4000_000A, 1'b0);
        push_beat(32'h4000_000B, 1'b0);
        push_beat(32'h4000_000C, 1'b1);
        n = 0;
        while (!bus_valid && n < 20) begin
            tick();
            n++;
        end
        chk("gl_first_beat", 64'(bus_valid), 64'd1);
        gnt_kill = 1'b1;
        tick();
        chk("gl_err", 64'(err_gnt_lost), 64'd1);
        chk("gl_no_beat", 64'(bus_valid), 64'd0);
        tick();
        chk("gl_err_pulse", 64'(err_gnt_lost), 64'd0);
        chk("gl_req_low", 64'(req), 64'd0);
        gnt_kill = 1'b0;
        wait_done();
        chk("gl_ntenure", 64'(tq.size()), 64'd2);
        if (tq.size() == 2) begin
            chk("gl_t0", 64'(tq[0]), 64'd1);
            chk("gl_t1", 64'(tq[1]), 64'd2);
        end

        // reset in the middle of a transfer flushes everything
        clear_stats();
        push_beat(32'h5000_0001, 1'b0);
        push_beat(32'h5000_0002, 1'b0);
        push_beat(32'h5000_0003, 1'b1);
        n = 0;
        while (cur_beats < 2 && n < 20) begin
            tick();
            n++;
        end
        chk("mr_two_beats", 64'(cur_beats), 64'd2);
        rst = 1'b1;
        q.delete();
        tick();
        rst = 1'b0;
        chk("mr_req", 64'(req), 64'd0);
        chk("mr_valid", 64'(bus_valid), 64'd0);
        chk("mr_data", 64'(bus_data), 64'd0);
        chk("mr_last", 64'(bus_last), 64'd0);
        chk("mr_err", 64'(err_gnt_lost), 64'd0);
        chk("mr_in_ready", 64'(in_ready), 64'd1);
        repeat (8) tick();
        chk("mr_no_rereq", 64'(req), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
